mem_rr_arbiter: RTL and testbench

//  Shares the 16x16 single-port register memory (en/wr/addr/wdata in, 1-cycle registered rdata)

---
 rtl/mem_arb_pkg.sv | 18 +
 rtl/mem_arb_rr_pick.sv | 27 ++
 rtl/mem_rr_arbiter.sv | 130 +++++++++++++
 tb/tb_mem_rr_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the round-robin memory arbiter.
package mem_arb_pkg;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 4;
  // Wide enough for up to four requesters.
  localparam int IDX_W = 2;

  typedef enum logic {INIT, RUN} state_t;

  typedef struct packed {
    logic             vld;
    logic [IDX_W-1:0] idx;
  } tag_t;

  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] v, input int n);
    return (int'(v) == n - 1) ? '0 : v + IDX_W'(1);
  endfunction
endpackage

// File: rtl/mem_arb_rr_pick.sv
// Combinational round-robin select: first valid requester at or after the pointer, wrapping.
module mem_arb_rr_pick import mem_arb_pkg::*; #(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               any_o
);
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    // k is the distance from the pointer; the nearest valid requester wins.
    for (int k = 0; k < NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!any_o && valid_i[i] &&
            ((int'(ptr_i) + k == i) || (int'(ptr_i) + k == i + NUM_REQ))) begin
          any_o      = 1'b1;
          grant_o[i] = 1'b1;
          idx_o      = IDX_W'(i);
        end
      end
    end
  end
endmodule

// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter sharing a single-port registered-read memory between NUM_REQ requesters.
module mem_rr_arbiter import mem_arb_pkg::*; #(
  parameter int NUM_REQ     = 2,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int INIT_CYCLES = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ-1:0]        req_wr,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      mem_rstn,
  output logic                      mem_en,
  output logic                      mem_wr,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  input  logic [DATA_W-1:0]         mem_rdata
);
  localparam int CNT_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(INIT_CYCLES - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic               mem_rstn_q, mem_en_q, mem_wr_q;
  logic [ADDR_W-1:0]  mem_addr_q;
  logic [DATA_W-1:0]  mem_wdata_q;
  tag_t               tag_p0_q, tag_p0_d, tag_p1_q;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]  rsp_rdata_q;

  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   gnt_idx;
  logic               gnt_any, run, accept, sel_wr;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_wdata;

  mem_arb_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .valid_i (req_valid),
    .ptr_i   (ptr_q),
    .grant_o (grant),
    .idx_o   (gnt_idx),
    .any_o   (gnt_any)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      INIT: if (cnt_q == CNT_LAST) state_d = RUN;
            else                   cnt_d   = cnt_q + CNT_W'(1);
      RUN:  state_d = RUN;
      default: state_d = INIT;
    endcase
  end

  assign run       = (state_q == RUN);
  assign accept    = run & gnt_any;
  assign req_ready = run ? grant : '0;

  always_comb begin
    sel_wr    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_wr    = req_wr[i];
        sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  assign ptr_d        = accept ? wrap_inc(gnt_idx, NUM_REQ) : ptr_q;
  assign tag_p0_d.vld = accept & ~sel_wr;
  assign tag_p0_d.idx = gnt_idx;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++)
      rsp_valid_d[i] = tag_p1_q.vld && (tag_p1_q.idx == IDX_W'(i));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= INIT;
      cnt_q       <= '0;
      ptr_q       <= '0;
      mem_rstn_q  <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      tag_p0_q    <= '0;
      tag_p1_q    <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ptr_q      <= ptr_d;
      mem_rstn_q <= (state_d == RUN);
      // p0: issue to memory on the edge after accept
      mem_en_q   <= accept;
      mem_wr_q   <= accept & sel_wr;
      if (accept) begin
        mem_addr_q  <= sel_addr;
        mem_wdata_q <= sel_wdata;
      end
      tag_p0_q <= tag_p0_d;
      // p1: memory samples the access
      tag_p1_q <= tag_p0_q;
      // p2: capture read data and pulse the originator
      rsp_valid_q <= rsp_valid_d;
      if (tag_p1_q.vld) rsp_rdata_q <= mem_rdata;
    end
  end

  assign mem_rstn  = mem_rstn_q;
  assign mem_en    = mem_en_q;
  assign mem_wr    = mem_wr_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Bench for mem_rr_arbiter with a behavioural memory and a transaction-level reference model.
module tb_mem_rr_arbiter;
  localparam int N  = 2;
  localparam int DW = 16;
  localparam int AW = 4;
  localparam int IC = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req_valid, req_ready, req_wr, rsp_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [DW-1:0]   rsp_rdata, mem_wdata, mem_rdata;
  logic            mem_rstn, mem_en, mem_wr;
  logic [AW-1:0]   mem_addr;

  mem_rr_arbiter #(.NUM_REQ(N), .DATA_W(DW), .ADDR_W(AW), .INIT_CYCLES(IC)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .mem_rstn(mem_rstn), .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // 16x16 single-port memory: sync active-low clear, registered read data
  logic [DW-1:0] mem_arr [16];
  always @(posedge clk) begin
    if (!mem_rstn) begin
      for (int i = 0; i < 16; i++) mem_arr[i] <= '0;
      mem_rdata <= '0;
    end else if (mem_en) begin
      if (mem_wr) mem_arr[mem_addr] <= mem_wdata;
      else        mem_rdata <= mem_arr[mem_addr];
    end
  end

  typedef struct packed {
    logic [N-1:0]  rdy;
    logic [N-1:0]  rv;
    logic [DW-1:0] rd;
    logic          rstn;
    logic          en;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
  } snap_t;

  typedef struct {
    int            due;
    int            idx;
    logic [DW-1:0] data;
  } rsp_t;

  int            total, bad, cyc, m_ptr, m_init;
  bit            m_run;
  logic [DW-1:0] ref_mem [16];
  logic [DW-1:0] m_last, m_wd;
  logic          m_en, m_wr;
  logic [AW-1:0] m_addr;
  rsp_t          pend[$];

  task automatic model_reset();
    m_run = 0; m_init = 0; m_ptr = 0; m_last = '0; m_en = 0; m_wr = 0;
    m_addr = '0; m_wd = '0; pend.delete();
    for (int i = 0; i < 16; i++) ref_mem[i] = '0;
  endtask

  task automatic set_req(input int i, input bit v, input bit w, input int a, input logic [DW-1:0] d);
    logic [31:0] av;
    av = a;
    req_valid[i] = v;
    req_wr[i]    = w;
    req_addr[i*AW +: AW]  = av[AW-1:0];
    req_wdata[i*DW +: DW] = d;
  endtask

  // One clock: observe ready before the edge, everything else after; advance the reference model.
  task automatic step(output snap_t o, output snap_t e);
    int g, best, d, a;
    #1;
    o.rdy = req_ready;
    g = -1;
    best = N;
    if (m_run) begin
      for (int i = 0; i < N; i++) begin
        d = (i - m_ptr + N) % N;
        if (req_valid[i] && d < best) begin best = d; g = i; end
      end
    end
    e.rdy = (g >= 0) ? N'(1 << g) : '0;
    m_en = 0;
    m_wr = 0;
    if (g >= 0) begin
      a = int'(req_addr[g*AW +: AW]);
      m_en = 1;
      m_wr = req_wr[g];
      m_addr = req_addr[g*AW +: AW];
      m_wd = req_wdata[g*DW +: DW];
      if (req_wr[g]) ref_mem[a] = req_wdata[g*DW +: DW];
      else pend.push_back('{cyc + 3, g, ref_mem[a]});
      m_ptr = (g + 1) % N;
    end
    @(posedge clk);
    cyc++;
    if (!m_run) begin
      m_init++;
      if (m_init == IC) m_run = 1;
    end
    #1;
    e.rv = '0;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      e.rv = N'(1 << pend[0].idx);
      m_last = pend[0].data;
      void'(pend.pop_front());
    end
    e.rd = m_last; e.rstn = m_run; e.en = m_en; e.wr = m_wr; e.addr = m_addr; e.wd = m_wd;
    o.rv = rsp_valid; o.rd = rsp_rdata; o.rstn = mem_rstn; o.en = mem_en; o.wr = mem_wr;
    o.addr = mem_addr; o.wd = mem_wdata;
    @(negedge clk);
  endtask

  task automatic test_reset();
    snap_t o, e;
    logic [N-1:0] want;
    rst = 1;
    set_req(0, 1, 0, 0, 16'h0);
    set_req(1, 1, 0, 1, 16'h0);
    @(posedge clk);
    @(negedge clk);
    total++;
    if ({req_ready, rsp_valid, rsp_rdata, mem_rstn, mem_en, mem_wr, mem_addr, mem_wdata} !== '0) begin
      bad++;
      $display("FAIL reset_state got rdy=%b rv=%b rd=%h rstn=%b en=%b wr=%b addr=%h wd=%h want all zero",
               req_ready, rsp_valid, rsp_rdata, mem_rstn, mem_en, mem_wr, mem_addr, mem_wdata);
    end
    rst = 0;
    model_reset();
    for (int k = 0; k < 3; k++) begin
      step(o, e);
      total++;
      if (o !== e) begin bad++; $display("FAIL reset_seq%0d got=%h want=%h", k, o, e); end
      want = (k == 2) ? 2'b01 : 2'b00;
      total++;
      if (o.rdy !== want) begin bad++; $display("FAIL reset_ready%0d got=%b want=%b", k, o.rdy, want); end
      if (k < 2) begin
        total++;
        if (o.rstn !== (k >= 1)) begin
          bad++; $display("FAIL reset_rstn%0d got=%b want=%b", k, o.rstn, (k >= 1));
        end
      end
    end
    req_valid = '0;
    for (int k = 0; k < 3; k++) begin
      step(o, e);
      total++;
      if (o !== e) begin bad++; $display("FAIL reset_drain%0d got=%h want=%h", k, o, e); end
    end
  endtask

  task automatic test_write_read();
    snap_t o, e;
    set_req(0, 1, 1, 3, 16'hBEEF);
    step(o, e);
    total++;
    if (o !== e) begin bad++; $display("FAIL wr_accept got=%h want=%h", o, e); end
    set_req(0, 1, 0, 3, 16'h0);
    step(o, e);
    total++;
    if (o !== e) begin bad++; $display("FAIL rd_accept got=%h want=%h", o, e); end
    req_valid = '0;
    for (int k = 0; k < 3; k++) begin
      step(o, e);
      total++;
      if (o !== e) begin bad++; $display("FAIL wr_rd_drain%0d got=%h want=%h", k, o, e); end
      if (k == 1) begin
        total++;
        if (o.rv !== 2'b01 || o.rd !== 16'hBEEF) begin
          bad++; $display("FAIL wr_rd_data got rv=%b rd=%h want rv=01 rd=beef", o.rv, o.rd);
        end
      end
    end
  endtask

  task automatic test_contention();
    snap_t o, e;
    logic [N-1:0] prev;
    set_req(0, 1, 0, 5, 16'h0);
    set_req(1, 1, 0, 9, 16'h0);
    prev = '0;
    for (int k = 0; k < 8; k++) begin
      step(o, e);
      total++;
      if (o !== e) begin bad++; $display("FAIL contend%0d got=%h want=%h", k, o, e); end
      if (k > 0) begin
        total++;
        if (o.rdy !== ~prev) begin bad++; $display("FAIL contend_alt%0d got=%b want=%b", k, o.rdy, ~prev); end
      end
      prev = o.rdy;
    end
    req_valid = '0;
    for (int k = 0; k < 3; k++) begin
      step(o, e);
      total++;
      if (o !== e) begin bad++; $display("FAIL contend_drain%0d got=%h want=%h", k, o, e); end
    end
  endtask

  task automatic test_fairness();
    snap_t o, e;
    set_req(0, 0, 0, 0, 16'h0);
    set_req(1, 1, 0, 2, 16'h0);
    for (int k = 0; k < 3; k++) begin
      step(o, e);
      total++;
      if (o !== e) begin bad++; $display("FAIL fair_solo%0d got=%h want=%h", k, o, e); end
    end
    set_req(0, 1, 0, 4, 16'h0);
    step(o, e);
    total++;
    if (o.rdy !== 2'b01) begin bad++; $display("FAIL fair_grant got=%b want=01", o.rdy); end
    total++;
    if (o !== e) begin bad++; $display("FAIL fair_both got=%h want=%h", o, e); end
    req_valid = '0;
    for (int k = 0; k < 3; k++) begin
      step(o, e);
      total++;
      if (o !== e) begin bad++; $display("FAIL fair_drain%0d got=%h want=%h", k, o, e); end
    end
  endtask

  task automatic test_hazard();
    snap_t o, e;
    set_req(0, 1, 1, 15, 16'h1234);
    set_req(1, 0, 0, 0, 16'h0);
    step(o, e);
    total++;
    if (o !== e) begin bad++; $display("FAIL haz_wr got=%h want=%h", o, e); end
    set_req(0, 0, 0, 0, 16'h0);
    set_req(1, 1, 0, 15, 16'h0);
    step(o, e);
    total++;
    if (o !== e) begin bad++; $display("FAIL haz_rd got=%h want=%h", o, e); end
    req_valid = '0;
    for (int k = 0; k < 3; k++) begin
      step(o, e);
      total++;
      if (o !== e) begin bad++; $display("FAIL haz_drain%0d got=%h want=%h", k, o, e); end
      if (k == 1) begin
        total++;
        if (o.rv !== 2'b10 || o.rd !== 16'h1234) begin
          bad++; $display("FAIL haz_data got rv=%b rd=%h want rv=10 rd=1234", o.rv, o.rd);
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    snap_t o, e;
    set_req(0, 1, 1, 7, 16'h5A5A);
    set_req(1, 0, 0, 0, 16'h0);
    step(o, e);
    total++;
    if (o !== e) begin bad++; $display("FAIL mid_wr got=%h want=%h", o, e); end
    set_req(0, 1, 0, 7, 16'h0);
    step(o, e);
    total++;
    if (o !== e) begin bad++; $display("FAIL mid_rd got=%h want=%h", o, e); end
    rst = 1;
    req_valid = '0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      total++;
      if (rsp_valid !== '0) begin bad++; $display("FAIL mid_drop%0d got=%b want=00", k, rsp_valid); end
    end
    @(negedge clk);
    rst = 0;
    model_reset();
    for (int k = 0; k < IC; k++) begin
      step(o, e);
      total++;
      if (o !== e) begin bad++; $display("FAIL mid_init%0d got=%h want=%h", k, o, e); end
    end
    set_req(0, 1, 0, 7, 16'h0);
    step(o, e);
    req_valid = '0;
    for (int k = 0; k < 3; k++) begin
      step(o, e);
      total++;
      if (o !== e) begin bad++; $display("FAIL mid_after%0d got=%h want=%h", k, o, e); end
      if (k == 1) begin
        total++;
        if (o.rv !== 2'b01 || o.rd !== 16'h0000) begin
          bad++; $display("FAIL mid_cleared got rv=%b rd=%h want rv=01 rd=0000", o.rv, o.rd);
        end
      end
    end
  endtask

  task automatic test_random();
    snap_t o, e;
    int errs;
    errs = 0;
    req_valid = '0;
    for (int k = 0; k < 300; k++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && ($urandom_range(0, 2) != 0))
          set_req(i, 1, $urandom_range(0, 1) == 1, $urandom_range(0, 7), DW'($urandom));
      end
      step(o, e);
      total++;
      if (o !== e) begin
        bad++;
        if (errs < 10) $display("FAIL random%0d got=%h want=%h", k, o, e);
        errs++;
      end
      for (int i = 0; i < N; i++) if (e.rdy[i]) req_valid[i] = 1'b0;
    end
    req_valid = '0;
    for (int k = 0; k < 4; k++) begin
      step(o, e);
      total++;
      if (o !== e) begin bad++; $display("FAIL random_drain%0d got=%h want=%h", k, o, e); end
    end
  endtask

  initial begin
    total = 0; bad = 0; cyc = 0;
    req_valid = '0; req_wr = '0; req_addr = '0; req_wdata = '0;
    model_reset();
    test_reset();
    test_write_read();
    test_contention();
    test_fairness();
    test_hazard();
    test_mid_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
